// File: rtl/x_delay_line_ctrl.sv
// Measurement sequencer for a 32-tap delay line: decodes each thermometer
// snapshot to an edge position and accumulates min/max/mean/bubbles per window.
module x_delay_line_ctrl #(
  parameter int LOG2_N = 4,
  parameter int SETTLE = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dl_data,
  input  logic        i_dl_valid,
  input  logic        i_start,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [5:0]  o_min,
  output logic [5:0]  o_max,
  output logic [5:0]  o_mean,
  output logic [8:0]  o_bubbles
);

  localparam int          N         = 1 << LOG2_N;
  localparam logic [8:0]  N_M1      = 9'(N - 1);
  localparam logic [7:0]  SETTLE_M1 = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_RESULT
  } state_t;

  state_t state, state_nxt;

  // Returns {bubble, pos}. The first bit differing from bit 0 marks the edge;
  // every bit beyond it must match that bit, otherwise the sample has a bubble.
  function automatic logic [6:0] decode_edge(input logic [31:0] d);
    logic       found;
    logic       stale_bit;
    logic       bub;
    logic [5:0] pos;
    found     = 1'b0;
    stale_bit = d[0];
    bub       = 1'b0;
    pos       = 6'd32;
    for (int j = 1; j < 32; j++) begin
      if (!found) begin
        if (d[j] != d[0]) begin
          found     = 1'b1;
          pos       = 6'(j);
          stale_bit = d[j];
        end
      end else if (d[j] != stale_bit) begin
        bub = 1'b1;
      end
    end
    return {bub, pos};
  endfunction

  // Stage D: snapshot register
  logic [31:0] data_p0;
  logic        vld_p0;

  always_ff @(posedge i_clk) begin
    data_p0 <= i_dl_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vld_p0 <= 1'b0;
    else          vld_p0 <= i_dl_valid;
  end

  // Decoded sample, consumed by the sequencer below
  logic [6:0]  dec_p0;
  logic [5:0]  pos_p0;
  logic        bub_p0;
  assign dec_p0 = decode_edge(data_p0);
  assign pos_p0 = dec_p0[5:0];
  assign bub_p0 = dec_p0[6];

  logic [7:0]  settle_cnt;
  logic [8:0]  smp_cnt;
  logic [5:0]  min_acc, max_acc;
  logic [13:0] sum_acc;
  logic [8:0]  bub_acc;

  logic [5:0]  min_nxt, max_nxt;
  logic [13:0] sum_nxt;
  logic [8:0]  bub_nxt;

  assign min_nxt = (pos_p0 < min_acc) ? pos_p0 : min_acc;
  assign max_nxt = (pos_p0 > max_acc) ? pos_p0 : max_acc;
  assign sum_nxt = sum_acc + 14'(pos_p0);
  assign bub_nxt = bub_acc + 9'(bub_p0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (i_start) state_nxt = (SETTLE == 0) ? ST_MEASURE : ST_SETTLE;
      ST_SETTLE:  if (vld_p0 && settle_cnt == SETTLE_M1) state_nxt = ST_MEASURE;
      ST_MEASURE: if (vld_p0 && smp_cnt == N_M1) state_nxt = ST_RESULT;
      ST_RESULT:  if (o_res_valid && i_res_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    // abort overrides everything, including a start in IDLE
    if (i_abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      settle_cnt <= '0;
      smp_cnt    <= '0;
      min_acc    <= '0;
      max_acc    <= '0;
      sum_acc    <= '0;
      bub_acc    <= '0;
    end else if (state == ST_IDLE && state_nxt != ST_IDLE) begin
      settle_cnt <= '0;
      smp_cnt    <= '0;
      min_acc    <= 6'd63;
      max_acc    <= '0;
      sum_acc    <= '0;
      bub_acc    <= '0;
    end else if (state == ST_SETTLE && vld_p0) begin
      settle_cnt <= settle_cnt + 8'd1;
    end else if (state == ST_MEASURE && vld_p0) begin
      smp_cnt <= smp_cnt + 9'd1;
      min_acc <= min_nxt;
      max_acc <= max_nxt;
      sum_acc <= sum_nxt;
      bub_acc <= bub_nxt;
    end
  end

  // Result registers capture the final sample in the same cycle as the load
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_min       <= '0;
      o_max       <= '0;
      o_mean      <= '0;
      o_bubbles   <= '0;
      o_res_valid <= 1'b0;
    end else begin
      if (state == ST_MEASURE && state_nxt == ST_RESULT) begin
        o_min     <= min_nxt;
        o_max     <= max_nxt;
        o_mean    <= 6'(sum_nxt >> LOG2_N);
        o_bubbles <= bub_nxt;
      end
      o_res_valid <= (state == ST_RESULT) && (state_nxt == ST_RESULT);
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_x_delay_line_ctrl.sv
// Directed bench for x_delay_line_ctrl (LOG2_N=4, SETTLE=2).
module tb_x_delay_line_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dl_data;
  logic        dl_valid;
  logic        start;
  logic        abort;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [5:0]  o_min, o_max, o_mean;
  logic [8:0]  o_bubbles;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk = ~clk;

  x_delay_line_ctrl #(.LOG2_N(4), .SETTLE(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_dl_data   (dl_data),
    .i_dl_valid  (dl_valid),
    .i_start     (start),
    .i_abort     (abort),
    .o_busy      (busy),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_min       (o_min),
    .o_max       (o_max),
    .o_mean      (o_mean),
    .o_bubbles   (o_bubbles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int mn, input int mx, input int me, input int bb);
    chk({tag, ".min"},  32'(o_min),     32'(mn));
    chk({tag, ".max"},  32'(o_max),     32'(mx));
    chk({tag, ".mean"}, 32'(o_mean),    32'(me));
    chk({tag, ".bub"},  32'(o_bubbles), 32'(bb));
  endtask

  // mode 0: 0xFF; 1: alternating 0xF / 0xFFFFF000; 2: one bubble sample; 3: 0xFFFF with 7-cycle valid gap
  task automatic do_window(input int mode, output int cycles);
    int cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 1;
    while (!res_valid && cnt < 200) begin
      case (mode)
        1:       dl_data = cnt[0] ? 32'h0000000F : 32'hFFFFF000;
        2:       dl_data = (cnt == 4) ? 32'h00F000FF : 32'h000000FF;
        3: begin
          dl_data  = 32'h0000FFFF;
          dl_valid = !(cnt >= 6 && cnt <= 12);
        end
        default: dl_data = 32'h000000FF;
      endcase
      tick();
      cnt++;
    end
    dl_data  = 32'h000000FF;
    dl_valid = 1'b1;
    cycles = cnt;
  endtask

  task automatic accept(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, ".vld_drop"}, 32'(res_valid), 32'd0);
    chk({tag, ".idle"},     32'(busy),      32'd0);
  endtask

  initial begin
    rst_n = 1'b0; dl_data = 32'h000000FF; dl_valid = 1'b1;
    start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.vld",  32'(res_valid), 32'd0);
    chk_res("rst", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // steady edge at tap 8
    do_window(0, lat);
    chk("w0.lat", 32'(lat), 32'd20);
    chk("w0.busy", 32'(busy), 32'd1);
    chk_res("w0", 8, 8, 8, 0);
    accept("w0");

    // alternating rising/falling fronts
    do_window(1, lat);
    chk("w1.lat", 32'(lat), 32'd20);
    chk_res("w1", 4, 12, 8, 0);
    accept("w1");

    // single bubble sample
    do_window(2, lat);
    chk("w2.lat", 32'(lat), 32'd20);
    chk_res("w2", 8, 8, 8, 1);
    accept("w2");

    // backpressure with an ignored start mid-hold
    do_window(0, lat);
    chk("w3.lat", 32'(lat), 32'd20);
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
      chk("hold.vld", 32'(res_valid), 32'd1);
      chk("hold.min", 32'(o_min), 32'd8);
    end
    start = 1'b0;
    chk("hold.busy", 32'(busy), 32'd1);
    chk_res("hold", 8, 8, 8, 0);
    accept("hold");
    tick(); tick(); tick();
    chk("hold.noqueue", 32'(busy), 32'd0);

    // valid gap of 7 cycles mid-window
    do_window(3, lat);
    chk("gap.lat", 32'(lat), 32'd27);
    chk_res("gap", 16, 16, 16, 0);
    accept("gap");

    // abort after 3 window samples of bubbly pos-1 data
    start = 1'b1;
    tick();
    start = 1'b0;
    dl_data = 32'h00F00001;
    for (int c = 1; c < 6; c++) tick();
    chk("abt.busy_pre", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    dl_data = 32'h000000FF;
    chk("abt.busy", 32'(busy), 32'd0);
    chk("abt.vld",  32'(res_valid), 32'd0);
    chk_res("abt.hold", 16, 16, 16, 0);
    do_window(0, lat);
    chk("fresh.lat", 32'(lat), 32'd20);
    chk_res("fresh", 8, 8, 8, 0);
    accept("fresh");

    // abort beats start in IDLE
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abtstart.busy", 32'(busy), 32'd0);
    tick();
    chk("abtstart.busy2", 32'(busy), 32'd0);

    // asynchronous reset mid-MEASURE after 5 samples
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    chk("mrst.busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.vld",  32'(res_valid), 32'd0);
    chk_res("mrst", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/x_delay_line_ctrl.md
Name: x_delay_line_ctrl

Overview:
- Measurement sequencer for the 32-tap delay line.
- Takes the line's per-cycle thermometer snapshot and valid strobe, then decodes each snapshot to an edge position (0..32).
- On command, runs a settle phase followed by a measurement window of 2^LOG2_N samples, tracking min, max, sum and bubble count.
- Presents one result record through a valid/ready handshake to the register/readout logic.

Parameters:
- LOG2_N, 4, log2 of samples per measurement window (legal 0..8).
- SETTLE, 8, number of valid samples discarded after start (legal 0..255).

Ports:
- i_clk  in  1  clock; the same clock that samples the delay line.
- i_rst_n  in  1  asynchronous active-low reset.
- i_dl_data  in  32  delay-line snapshot; bit 0 is the tap nearest the line input.
- i_dl_valid  in  1  snapshot qualifier from the delay line.
- i_start  in  1  single-cycle pulse that requests a measurement.
- i_abort  in  1  returns the block to IDLE; any partial result is discarded.
- o_busy  out  1  high in SETTLE, MEASURE and RESULT.
- o_res_valid  out  1  result record is available.
- i_res_ready  in  1  consumer accepts the record.
- o_min  out  6  minimum edge position in the window.
- o_max  out  6  maximum edge position in the window.
- o_mean  out  6  sum >> LOG2_N, truncated.
- o_bubbles  out  9  count of window samples that contained a bubble.

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - FSM goes to IDLE; all outputs 0; accumulators cleared.
- Decode pipeline (stage D), 1 cycle:
  - Register i_dl_data and i_dl_valid.
  - pos = length of the run of bits equal to bit 0, counted upward from bit 0. Range 1..32; 32 when all bits are equal.
  - Let k = pos. bubble = 1 if any bit j > k differs from bit k, i.e. the stale region is not uniform.
  - Polarity-agnostic: rising and falling wavefronts decode identically.
  - Decoded sample valid (dv) is asserted 1 cycle after i_dl_valid.
- FSM states: IDLE, SETTLE, MEASURE, RESULT.
  - IDLE:
    - i_start → SETTLE, with settle counter = 0, sample counter = 0, min = 63, max = 0, sum = 0, bubbles = 0.
    - If SETTLE == 0, go directly to MEASURE.
  - SETTLE:
    - Each dv increments the settle counter.
    - On the dv that brings the count to SETTLE → MEASURE.
    - Discarded samples never touch the accumulators.
  - MEASURE:
    - On each dv: min = min(min, pos); max = max(max, pos); sum += pos (14-bit, no overflow for LOG2_N ≤ 8); bubbles += bubble; sample counter += 1.
    - On the dv that is sample 2^LOG2_N → RESULT. Output registers are loaded in the same cycle, including that final sample.
    - o_res_valid rises the following cycle.
  - RESULT:
    - o_res_valid = 1; outputs held stable.
    - When i_res_ready = 1 → IDLE; o_res_valid drops the next cycle. Outputs keep their last value until the next load.
- i_start outside IDLE is ignored; no queuing.
- i_abort in any non-IDLE state → IDLE next cycle; o_res_valid = 0; outputs unchanged.
- If i_abort and i_start are high in the same cycle in IDLE, i_abort wins and the block stays in IDLE.
- i_dl_valid gaps: the FSM waits indefinitely; no timeout.
- o_busy = (state != IDLE).
- Min and max are initialised per window, so window results never carry over from previous windows.

Test Plan:
- Reset mid-MEASURE (after 5 samples) → all outputs 0, state IDLE, o_busy = 0 immediately (asynchronous).
- LOG2_N = 4, SETTLE = 2, data 0x000000FF every cycle with i_dl_valid = 1, i_start pulse → 2 samples discarded, then 16 accumulated. Expect o_min = o_max = o_mean = 8, o_bubbles = 0, o_res_valid high 1 + 2 + 16 + 1 cycles after start.
- Same window with data alternating 0x0000000F and 0xFFFFF000 → o_min = 4, o_max = 12, o_mean = 8.
- One sample = 0x00F000FF, rest 0x000000FF → o_bubbles = 1, o_min = o_max = 8.
- Hold i_res_ready = 0 for 10 cycles in RESULT, pulse i_start mid-hold → outputs stable, start ignored, record accepted once ready rises.
- i_dl_valid low for 7 cycles mid-MEASURE → window completes after exactly 16 valid samples. Separately: i_abort at sample 3, then new start → fresh result with no carry-over.
